// File: rtl/hilo_md_ctrl.sv
// Issue-side controller for the 32-bit mult/div unit plus the architectural HI/LO pair.
// Launches the unit with a one-cycle md pulse, waits for its write strobe, and stalls EX meanwhile.
module hilo_md_ctrl #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_req,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  input  logic        mf_sel,
  input  logic        mt_req,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic        md,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        mult_busy,
  input  logic        div_busy,
  input  logic        mult_write,
  input  logic        div_write,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             dz_q, dz_d;
  logic             err_q, err_d;
  logic             launch;
  logic             strobe;
  logic             strobe_both;

  assign strobe      = mult_write | div_write;
  assign strobe_both = mult_write & div_write;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wd_d    = wd_q;
    dz_d    = 1'b0;
    err_d   = err_q;
    launch  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (md_req) begin
          // Divides by zero are dropped here so the unit never sees them.
          if (md_op[1] && (rt_val == 32'd0)) begin
            dz_d = 1'b1;
          end else begin
            op_d    = md_op;
            a_d     = rs_val;
            b_d     = rt_val;
            launch  = 1'b1;
            state_d = StIssue;
          end
        end else if (mt_req) begin
          if (mt_sel) lo_d = mt_data;
          else        hi_d = mt_data;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (strobe && !strobe_both) begin
          hi_d    = md_hi;
          lo_d    = md_lo;
          state_d = StIdle;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Protocol violations only flag err; the offending strobe is not captured.
    if (strobe && (state_q != StWait)) err_d = 1'b1;
    if (strobe_both)                   err_d = 1'b1;
    if (mult_busy && div_busy)         err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      wd_q    <= '0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
    end
  end

  assign md      = (state_q == StIssue);
  assign stall   = ((state_q != StIdle) & (md_req | mf_req | mt_req)) | launch;
  assign mf_data = mf_sel ? lo_q : hi_q;
  assign alu_op  = op_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign dz      = dz_q;
  assign err     = err_q;

endmodule
